mdu_sequencer: RTL and testbench

- Multi-cycle sequencer for MUL (low 32 bits), DIVU and REMU.
- Has no adder or comparator of its own: borrows the shared execute-stage ALU over a dedicated port and issues one ALU operation per cycle.
- Sits beside the ALU in the execute stage. While alu_own is high, the datapath muxes the ALU inputs from this block and stalls the pipeline.

---
 rtl/mdu_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Multi-cycle MUL (low word) / DIVU / REMU sequencer that borrows the shared execute-stage ALU.
// Latency from start-sampling edge: MUL done in cycle 33, DIVU/REMU cycle 65, div-by-zero/reserved cycle 1.
// No backpressure: start is taken only in IDLE, ignored while busy; kill aborts to IDLE with no done.
// Ports:
//   clk, reset_n            rising-edge clock, async active-low reset
//   start, kill, mdu_op     request pulse, synchronous abort, 00 MUL / 01 DIVU / 10 REMU / 11 reserved
//   op_a, op_b              operands, captured with an accepted start
//   busy, done, result      status, one-cycle completion pulse, registered result
//   alu_own, alu_src*, alu_op, alu_result   borrowed ALU port (drives are zero when not owned)
module mdu_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     kill,
  input  logic [1:0]               mdu_op,
  input  logic [DATA_WIDTH-1:0]    op_a,
  input  logic [DATA_WIDTH-1:0]    op_b,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     alu_own,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result
);

  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD = 4'b1011;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SUB = 4'b1010;
  localparam logic [OPCODE_LENGTH-1:0] ALU_GE  = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_ADD,
    S_DIV_CMP,
    S_DIV_SUB,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [5:0]              count_q, count_d;
  logic [1:0]              op_q, op_d;
  // acc_q: product accumulator (MUL) or partial remainder (DIV)
  // opb_q: shifting multiplicand (MUL) or fixed divisor (DIV)
  // shf_q: multiplier shifted right (MUL) or dividend/quotient shifted left (DIV)
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   opb_q, opb_d;
  logic [DATA_WIDTH-1:0]   shf_q, shf_d;
  logic                    ge_q, ge_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [DATA_WIDTH-1:0]   rs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      shf_q    <= '0;
      ge_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      shf_q    <= shf_d;
      ge_q     <= ge_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    shf_d    = shf_q;
    ge_d     = ge_q;
    result_d = result_q;
    alu_own  = 1'b0;
    alu_srca = '0;
    alu_srcb = '0;
    alu_op   = '0;
    // Next partial remainder: shift in the top dividend bit.
    rs       = {acc_q[DATA_WIDTH-2:0], shf_q[DATA_WIDTH-1]};

    case (state_q)
      S_IDLE: begin
        // kill wins over a coincident start.
        if (start && !kill) begin
          op_d    = mdu_op;
          count_d = '0;
          case (mdu_op)
            2'b00: begin
              acc_d   = '0;
              opb_d   = op_a;
              shf_d   = op_b;
              state_d = S_MUL_ADD;
            end
            2'b01, 2'b10: begin
              if (op_b == '0) begin
                result_d = (mdu_op == 2'b01) ? '1 : op_a;
                state_d  = S_DONE;
              end else begin
                acc_d   = '0;
                opb_d   = op_b;
                shf_d   = op_a;
                state_d = S_DIV_CMP;
              end
            end
            default: begin
              result_d = '0;
              state_d  = S_DONE;
            end
          endcase
        end
      end
      S_MUL_ADD: begin
        alu_own  = 1'b1;
        alu_op   = ALU_ADD;
        alu_srca = acc_q;
        alu_srcb = opb_q;
        if (shf_q[0]) acc_d = alu_result;
        opb_d   = opb_q << 1;
        shf_d   = shf_q >> 1;
        count_d = count_q + 6'd1;
        if (count_q == 6'd31) begin
          result_d = acc_d;
          state_d  = S_DONE;
        end
      end
      S_DIV_CMP: begin
        alu_own  = 1'b1;
        alu_op   = ALU_GE;
        alu_srca = rs;
        alu_srcb = opb_q;
        acc_d    = rs;
        shf_d    = {shf_q[DATA_WIDTH-2:0], 1'b0};
        ge_d     = alu_result[0];
        state_d  = S_DIV_SUB;
      end
      S_DIV_SUB: begin
        alu_own  = 1'b1;
        alu_op   = ALU_SUB;
        alu_srca = acc_q;
        alu_srcb = opb_q;
        if (ge_q) begin
          acc_d    = alu_result;
          shf_d[0] = 1'b1;
        end
        count_d = count_q + 6'd1;
        if (count_q == 6'd31) begin
          result_d = (op_q == 2'b01) ? shf_d : acc_d;
          state_d  = S_DONE;
        end else begin
          state_d = S_DIV_CMP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush: abandon the operation; result keeps its last completed value.
    if (kill && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer with a behavioural model of the shared ALU.
// Expected result and completion cycle are queued at issue; a monitor checks them on every done.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_mdu_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        kill;
  logic [1:0]  mdu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        alu_own;
  logic [31:0] alu_srca;
  logic [31:0] alu_srcb;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;

  mdu_sequencer #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .kill       (kill),
    .mdu_op     (mdu_op),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .alu_own    (alu_own),
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .alu_op     (alu_op),
    .alu_result (alu_result)
  );

  // Shared ALU model
  always_comb begin
    case (alu_op)
      4'b1011: alu_result = alu_srca + alu_srcb;
      4'b1010: alu_result = alu_srca - alu_srcb;
      4'b0111: alu_result = {31'b0, (alu_srca >= alu_srcb)};
      default: alu_result = 32'h0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int own_cnt = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always @(negedge clk) if (alu_own) own_cnt <= own_cnt + 1;

  // Monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done result=%h cyc=%0d", result, cyc);
      end else begin
        e = sb.pop_front();
        if (result !== e.res || cyc != e.cyc) begin
          errors++;
          $display("FAIL done_result got=%h at cyc %0d, expected=%h at cyc %0d",
                   result, cyc, e.res, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  // lat = cycle (counted from the start-sampling edge as cycle 0) in which done shows.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] want, input int lat);
    exp_t x;
    @(negedge clk);
    start  = 1'b1;
    mdu_op = op;
    op_a   = a;
    op_b   = b;
    if (push) begin
      x.res = want;
      x.cyc = cyc + lat;
      sb.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout pending=%0d expected_done=1", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    {31'b0, busy},    32'h0);
    chk({tag, "_done"},    {31'b0, done},    32'h0);
    chk({tag, "_result"},  result,           32'h0);
    chk({tag, "_alu_own"}, {31'b0, alu_own}, 32'h0);
    chk({tag, "_srca"},    alu_srca,         32'h0);
    chk({tag, "_srcb"},    alu_srcb,         32'h0);
    chk({tag, "_alu_op"},  {28'b0, alu_op},  32'h0);
  endtask

  int o0;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    kill    = 1'b0;
    mdu_op  = 2'b00;
    op_a    = 32'h0;
    op_b    = 32'h0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // MUL 7 x 6: ALU owned for exactly 32 cycles starting in cycle 1
    o0 = own_cnt;
    issue(2'b00, 32'd7, 32'd6, 1'b1, 32'd42, 33);
    chk("mul_busy_c1",    {31'b0, busy},    32'h1);
    chk("mul_own_c1",     {31'b0, alu_own}, 32'h1);
    chk("mul_aluop_c1",   {28'b0, alu_op},  32'hB);
    wait_done();
    chk("mul_own_cycles", own_cnt - o0, 32'd32);

    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000001, 33);
    wait_done();
    issue(2'b00, 32'h00010000, 32'h00010000, 1'b1, 32'h00000000, 33);
    wait_done();

    // Division
    o0 = own_cnt;
    issue(2'b01, 32'd100, 32'd7, 1'b1, 32'd14, 65);
    wait_done();
    chk("div_own_cycles", own_cnt - o0, 32'd64);
    issue(2'b10, 32'd100, 32'd7, 1'b1, 32'd2, 65);
    wait_done();
    issue(2'b01, 32'hFFFFFFFF, 32'd1, 1'b1, 32'hFFFFFFFF, 65);
    wait_done();

    // Divide by zero and reserved opcode: immediate completion, no ALU use
    o0 = own_cnt;
    issue(2'b01, 32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 1);
    wait_done();
    issue(2'b11, 32'd9, 32'd4, 1'b1, 32'h0, 1);
    wait_done();
    issue(2'b10, 32'd5, 32'd0, 1'b1, 32'd5, 1);
    wait_done();
    chk("div0_own_cycles", own_cnt - o0, 32'd0);

    // start while busy is ignored
    issue(2'b01, 32'd100, 32'd7, 1'b1, 32'd14, 65);
    repeat (8) @(negedge clk);
    start  = 1'b1;
    mdu_op = 2'b00;
    op_a   = 32'd55;
    op_b   = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // kill mid-MUL: back to IDLE, no done, result keeps 14
    issue(2'b00, 32'd7, 32'd6, 1'b0, 32'h0, 0);
    repeat (18) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy",   {31'b0, busy},    32'h0);
    chk("kill_own",    {31'b0, alu_own}, 32'h0);
    chk("kill_result", result,           32'd14);
    repeat (40) @(negedge clk);
    chk("kill_result_held", result, 32'd14);

    // kill beats start in IDLE
    start  = 1'b1;
    kill   = 1'b1;
    mdu_op = 2'b01;
    op_a   = 32'd8;
    op_b   = 32'd0;
    @(negedge clk);
    start = 1'b0;
    kill  = 1'b0;
    chk("kill_start_busy", {31'b0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    chk("kill_start_result", result, 32'd14);

    // async reset mid-DIVU clears everything immediately
    issue(2'b01, 32'd100, 32'd7, 1'b0, 32'h0, 0);
    repeat (38) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (80) @(negedge clk);

    issue(2'b00, 32'd3, 32'd3, 1'b1, 32'd9, 33);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
